d5m_pattern_source: RTL

Synthetic D5M sensor that emits the same FVAL/LVAL/12-bit Bayer pixel stream the camera drives on GPIO1. It sits in place of `D5M_D`/`D5M_FVAL`/`D5M_LVAL` ahead of the capture stage. This lets capture, RAW2RGB, edge-detect, SDRAM and VGA be exercised in simulation and on the board without a camera. Frame geometry and blanking are parameterised, and four test patterns are selectable per frame.

---
 rtl/d5m_pkg.sv | 37 +++
 rtl/d5m_pattern_pixel.sv | 37 +++
 rtl/d5m_pattern_source.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/d5m_pkg.sv
// Shared types and constants for the synthetic D5M pattern source.
package d5m_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    LINE,
    HBLANK,
    TRAIL,
    VBLANK
  } state_t;

  typedef enum logic [1:0] {
    BARS,
    HRAMP,
    VRAMP,
    CHECK
  } pattern_t;

  // Bar colours as {R,G,B}, leftmost bar first.
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  localparam logic [11:0] PIX_MAX = 12'hFFF;

  // D5M Bayer site: even rows G/R, odd rows B/G (even x first).
  function automatic logic bayer_site_on(input logic [2:0] rgb,
                                         input logic       x_odd,
                                         input logic       y_odd);
    logic on;
    if (!y_odd) on = x_odd ? rgb[2] : rgb[1];
    else        on = x_odd ? rgb[1] : rgb[0];
    return on;
  endfunction

endpackage

// File: rtl/d5m_pattern_pixel.sv
// Combinational pixel generator: maps (x, y, pattern, frame parity) to a
// 12-bit Bayer sample.
module d5m_pattern_pixel
  import d5m_pkg::*;
#(
  parameter int ACTIVE_W = 640
)
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  pattern_t    mode,
  input  logic        frame_lsb,
  output logic [11:0] pix
);

  localparam logic [15:0] BAR_W = 16'(ACTIVE_W / 8);

  logic [15:0] bar_idx;
  logic        site_on;
  logic        unused_bits;

  assign bar_idx     = x / BAR_W;
  assign site_on     = bayer_site_on(BAR_RGB[bar_idx[2:0]], x[0], y[0]);
  assign unused_bits = ^{bar_idx[15:3], y[15:12]};

  always_comb begin
    pix = '0;
    case (mode)
      BARS:    pix = site_on ? PIX_MAX : '0;
      HRAMP:   pix = x[11:0];
      VRAMP:   pix = y[11:0];
      CHECK:   pix = (x[3] ^ y[3] ^ frame_lsb) ? PIX_MAX : '0;
      default: pix = '0;
    endcase
  end

endmodule

// File: rtl/d5m_pattern_source.sv
// Synthetic D5M sensor: generates FVAL/LVAL framing and a 12-bit Bayer test
// pattern stream in place of the camera's GPIO inputs.
module d5m_pattern_source
  import d5m_pkg::*;
#(
  parameter int ACTIVE_W = 640,
  parameter int ACTIVE_H = 480,
  parameter int H_BLANK  = 16,
  parameter int FV_LEAD  = 4,
  parameter int FV_TRAIL = 4,
  parameter int V_BLANK  = 64
)
(
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iRUN,
  input  logic [1:0]  iMODE,
  output logic [11:0] oDATA,
  output logic        oLVAL,
  output logic        oFVAL,
  output logic [31:0] oFrame_Cont,
  output logic        oBUSY
);

  localparam logic [15:0] X_LAST   = 16'(ACTIVE_W - 1);
  localparam logic [15:0] Y_LAST   = 16'(ACTIVE_H - 1);
  localparam logic [15:0] LEAD_LD  = 16'(FV_LEAD - 1);
  localparam logic [15:0] HBLK_LD  = 16'(H_BLANK - 1);
  localparam logic [15:0] TRAIL_LD = 16'(FV_TRAIL - 1);
  localparam logic [15:0] VBLK_LD  = 16'(V_BLANK - 1);

  state_t      state, state_n;
  logic [15:0] x, x_n;
  logic [15:0] y, y_n;
  logic [15:0] blank_cnt, blank_cnt_n;
  pattern_t    mode_q, mode_n;
  logic [31:0] frame_q, frame_n;
  logic [11:0] pix;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      blank_cnt <= '0;
      mode_q    <= BARS;
      frame_q   <= '0;
    end else begin
      state     <= state_n;
      x         <= x_n;
      y         <= y_n;
      blank_cnt <= blank_cnt_n;
      mode_q    <= mode_n;
      frame_q   <= frame_n;
    end
  end

  always_comb begin
    state_n     = state;
    x_n         = x;
    y_n         = y;
    blank_cnt_n = blank_cnt;
    mode_n      = mode_q;
    frame_n     = frame_q;
    case (state)
      IDLE: begin
        if (iRUN) begin
          mode_n      = pattern_t'(iMODE);
          x_n         = '0;
          y_n         = '0;
          blank_cnt_n = LEAD_LD;
          state_n     = LEAD;
        end
      end
      LEAD: begin
        if (blank_cnt == '0) state_n = LINE;
        else                 blank_cnt_n = blank_cnt - 16'd1;
      end
      LINE: begin
        if (x == X_LAST) begin
          if (y == Y_LAST) begin
            blank_cnt_n = TRAIL_LD;
            state_n     = TRAIL;
          end else begin
            blank_cnt_n = HBLK_LD;
            state_n     = HBLANK;
          end
        end else begin
          x_n = x + 16'd1;
        end
      end
      HBLANK: begin
        if (blank_cnt == '0) begin
          x_n     = '0;
          y_n     = y + 16'd1;
          state_n = LINE;
        end else begin
          blank_cnt_n = blank_cnt - 16'd1;
        end
      end
      TRAIL: begin
        if (blank_cnt == '0) begin
          frame_n     = frame_q + 32'd1;
          blank_cnt_n = VBLK_LD;
          state_n     = VBLANK;
        end else begin
          blank_cnt_n = blank_cnt - 16'd1;
        end
      end
      VBLANK: begin
        if (blank_cnt == '0) begin
          if (iRUN) begin
            mode_n      = pattern_t'(iMODE);
            x_n         = '0;
            y_n         = '0;
            blank_cnt_n = LEAD_LD;
            state_n     = LEAD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          blank_cnt_n = blank_cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  d5m_pattern_pixel #(
    .ACTIVE_W (ACTIVE_W)
  ) u_pixel (
    .x         (x),
    .y         (y),
    .mode      (mode_q),
    .frame_lsb (frame_q[0]),
    .pix       (pix)
  );

  // Output stage decodes the current state one edge later, so FVAL, LVAL,
  // data, busy and the frame count all move together with no skew.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oDATA       <= '0;
      oLVAL       <= 1'b0;
      oFVAL       <= 1'b0;
      oFrame_Cont <= '0;
      oBUSY       <= 1'b0;
    end else begin
      oFVAL       <= (state == LEAD) || (state == LINE) ||
                     (state == HBLANK) || (state == TRAIL);
      oLVAL       <= (state == LINE);
      oDATA       <= (state == LINE) ? pix : '0;
      oFrame_Cont <= frame_q;
      oBUSY       <= (state != IDLE);
    end
  end

endmodule
